// File: rtl/mul_div_seq.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and
// non-restoring divide on magnitudes, 32 iterations each, result on Zhigh/Zlow.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the start edge
// RUN   | one Booth or non-restoring step per cycle, 32 steps
// FIX   | remainder correction, sign fix, result and dbz written
// DONE  | done pulse, result stable, start ignored
module mul_div_seq (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] BusMuxOut,
    input  logic        Yin,
    input  logic        start,
    input  logic        op,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] Zhigh,
    output logic [31:0] Zlow
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] y_reg, a_reg, b_reg;
    logic        op_reg;
    logic [4:0]  cnt;
    logic [33:0] acc;
    logic [31:0] lo;
    logic        q1;

    logic [33:0] a_ext, booth_sum, d_ext, div_shift, div_sum;
    logic [31:0] b_mag, y_mag, rem_fix, q_signed, r_signed;

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (op && BusMuxOut == 32'd0) ? FIX : RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == 5'd31) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth: {acc, lo, q1} is the shifting product/multiplier pair
    always_comb begin
        a_ext = {{2{a_reg[31]}}, a_reg};
        case ({lo[0], q1})
            2'b01:   booth_sum = acc + a_ext;
            2'b10:   booth_sum = acc - a_ext;
            default: booth_sum = acc;
        endcase
    end

    // Non-restoring divide: acc is the signed partial remainder, lo shifts
    // the dividend magnitude out and the quotient bits in.
    always_comb begin
        b_mag     = b_reg[31] ? -b_reg : b_reg;
        y_mag     = y_reg[31] ? -y_reg : y_reg;
        d_ext     = {2'b00, b_mag};
        div_shift = {acc[32:0], lo[31]};
        div_sum   = acc[33] ? div_shift + d_ext : div_shift - d_ext;
        rem_fix   = acc[33] ? acc[31:0] + b_mag : acc[31:0];
        q_signed  = (a_reg[31] ^ b_reg[31]) ? -lo : lo;
        r_signed  = a_reg[31] ? -rem_fix : rem_fix;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            y_reg  <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            q1     <= 1'b0;
            dbz    <= 1'b0;
            Zhigh  <= '0;
            Zlow   <= '0;
        end else begin
            if (Yin) y_reg <= BusMuxOut;
            case (state)
                IDLE: if (start) begin
                    a_reg  <= y_reg;
                    b_reg  <= BusMuxOut;
                    op_reg <= op;
                    dbz    <= 1'b0;
                    cnt    <= '0;
                    acc    <= '0;
                    q1     <= 1'b0;
                    lo     <= op ? y_mag : BusMuxOut;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (op_reg) begin
                        acc <= div_sum;
                        lo  <= {lo[30:0], ~div_sum[33]};
                    end else begin
                        acc <= {booth_sum[33], booth_sum[33:1]};
                        lo  <= {booth_sum[0], lo[31:1]};
                        q1  <= lo[0];
                    end
                end
                FIX: begin
                    if (!op_reg) begin
                        Zhigh <= acc[31:0];
                        Zlow  <= lo;
                    end else if (b_reg == 32'd0) begin
                        Zhigh <= a_reg;
                        Zlow  <= 32'hFFFF_FFFF;
                        dbz   <= 1'b1;
                    end else begin
                        Zhigh <= r_signed;
                        Zlow  <= q_signed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed cases plus random operations
// checked against a plain-arithmetic reference model.
module tb_mul_div_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        Yin, start, op;
    logic        busy, done, dbz;
    logic [31:0] Zhigh, Zlow;

    int checks = 0;
    int errors = 0;

    mul_div_seq dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .Yin(Yin),
        .start(start), .op(op), .busy(busy), .done(done), .dbz(dbz),
        .Zhigh(Zhigh), .Zlow(Zlow)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic z);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        if (!o) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            z  = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    task automatic load_y(input logic [31:0] v);
        @(negedge clock);
        Yin = 1'b1;
        BusMuxOut = v;
        @(negedge clock);
        Yin = 1'b0;
    endtask

    // returns at the negedge right after the edge that samples start
    task automatic issue(input logic o, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        op = o;
        BusMuxOut = b;
        @(negedge clock);
        start = 1'b0;
        BusMuxOut = $urandom;
    endtask

    task automatic wait_done(output int lat, output bit bad);
        lat = 0;
        bad = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) bad = 1'b1;
            @(negedge clock);
            lat++;
        end
        if (busy !== 1'b0) bad = 1'b1;
    endtask

    task automatic test_reset;
        clear = 1'b1;
        repeat (2) @(negedge clock);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        if (Zhigh !== 32'd0) begin errors++; $display("FAIL reset_zhigh: got %h expected 0", Zhigh); end
        if (Zlow !== 32'd0) begin errors++; $display("FAIL reset_zlow: got %h expected 0", Zlow); end
        clear = 1'b0;
    endtask

    task automatic test_mul;
        logic [31:0] tab [3][4] = '{
            '{32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
            '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001}};
        int lat;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            load_y(tab[i][0]);
            issue(1'b0, tab[i][1]);
            wait_done(lat, bad);
            checks += 5;
            if (lat != 33) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
            if (bad) begin errors++; $display("FAIL mul_busy[%0d]: got bad busy/done overlap expected clean", i); end
            if (Zhigh !== tab[i][2]) begin errors++; $display("FAIL mul_zhigh[%0d]: got %h expected %h", i, Zhigh, tab[i][2]); end
            if (Zlow !== tab[i][3]) begin errors++; $display("FAIL mul_zlow[%0d]: got %h expected %h", i, Zlow, tab[i][3]); end
            if (dbz !== 1'b0) begin errors++; $display("FAIL mul_dbz[%0d]: got %b expected 0", i, dbz); end
            @(negedge clock);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse[%0d]: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_div;
        logic [31:0] tab [3][4] = '{
            '{32'd17,        32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD},
            '{32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
            '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000}};
        int lat;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            load_y(tab[i][0]);
            issue(1'b1, tab[i][1]);
            wait_done(lat, bad);
            checks += 5;
            if (lat != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            if (bad) begin errors++; $display("FAIL div_busy[%0d]: got bad busy/done overlap expected clean", i); end
            if (Zhigh !== tab[i][2]) begin errors++; $display("FAIL div_zhigh[%0d]: got %h expected %h", i, Zhigh, tab[i][2]); end
            if (Zlow !== tab[i][3]) begin errors++; $display("FAIL div_zlow[%0d]: got %h expected %h", i, Zlow, tab[i][3]); end
            if (dbz !== 1'b0) begin errors++; $display("FAIL div_dbz[%0d]: got %b expected 0", i, dbz); end
        end
    endtask

    task automatic test_dbz;
        int lat;
        bit bad;
        load_y(32'h1234);
        issue(1'b1, 32'd0);
        wait_done(lat, bad);
        checks += 5;
        if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        if (bad) begin errors++; $display("FAIL dbz_busy: got bad busy/done overlap expected clean"); end
        if (Zlow !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_zlow: got %h expected ffffffff", Zlow); end
        if (Zhigh !== 32'h1234) begin errors++; $display("FAIL dbz_zhigh: got %h expected 00001234", Zhigh); end
        if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
        load_y(32'd100);
        issue(1'b1, 32'd7);
        checks += 3;
        if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear_at_start: got %b expected 0", dbz); end
        if (busy !== 1'b1) begin errors++; $display("FAIL dbz_next_busy: got %b expected 1", busy); end
        if (Zlow !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_hold_zlow: got %h expected ffffffff", Zlow); end
        wait_done(lat, bad);
        checks += 3;
        if (lat != 33) begin errors++; $display("FAIL dbz_next_latency: got %0d expected 33", lat); end
        if (Zlow !== 32'd14) begin errors++; $display("FAIL dbz_next_zlow: got %h expected 0000000e", Zlow); end
        if (Zhigh !== 32'd2) begin errors++; $display("FAIL dbz_next_zhigh: got %h expected 00000002", Zhigh); end
    endtask

    task automatic test_interference;
        int ndone = 0;
        int lat = -1;
        bit bad;
        logic [31:0] hi = '0, lo = '0;
        load_y(32'd6);
        issue(1'b0, 32'd7);
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = i; hi = Zhigh; lo = Zlow; end
            end
            if (i == 5) begin start = 1'b1; op = 1'b1; Yin = 1'b1; BusMuxOut = 32'd99; end
            if (i == 6) begin start = 1'b0; Yin = 1'b0; end
            @(negedge clock);
        end
        checks += 4;
        if (ndone != 1) begin errors++; $display("FAIL intf_done_count: got %0d expected 1", ndone); end
        if (lat != 33) begin errors++; $display("FAIL intf_latency: got %0d expected 33", lat); end
        if (lo !== 32'd42) begin errors++; $display("FAIL intf_zlow: got %h expected 0000002a", lo); end
        if (hi !== 32'd0) begin errors++; $display("FAIL intf_zhigh: got %h expected 0", hi); end
        issue(1'b0, 32'd1);
        wait_done(lat, bad);
        checks += 2;
        if (Zlow !== 32'd99) begin errors++; $display("FAIL intf_y_zlow: got %h expected 00000063", Zlow); end
        if (Zhigh !== 32'd0) begin errors++; $display("FAIL intf_y_zhigh: got %h expected 0", Zhigh); end
    endtask

    task automatic test_clear_mid;
        int ndone = 0;
        int lat;
        bit bad;
        load_y(32'd5);
        issue(1'b0, 32'd9);
        repeat (10) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL clr_done: got %b expected 0", done); end
        if (dbz !== 1'b0) begin errors++; $display("FAIL clr_dbz: got %b expected 0", dbz); end
        if (Zhigh !== 32'd0) begin errors++; $display("FAIL clr_zhigh: got %h expected 0", Zhigh); end
        if (Zlow !== 32'd0) begin errors++; $display("FAIL clr_zlow: got %h expected 0", Zlow); end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clock);
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL clr_no_done: got %0d expected 0", ndone); end
        load_y(32'd3);
        issue(1'b0, 32'd4);
        wait_done(lat, bad);
        checks += 3;
        if (lat != 33) begin errors++; $display("FAIL clr_next_latency: got %0d expected 33", lat); end
        if (Zlow !== 32'd12) begin errors++; $display("FAIL clr_next_zlow: got %h expected 0000000c", Zlow); end
        if (Zhigh !== 32'd0) begin errors++; $display("FAIL clr_next_zhigh: got %h expected 0", Zhigh); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, ehi, elo, phi, plo;
        logic        o, ez;
        int lat;
        bit bad;
        phi = Zhigh;
        plo = Zlow;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 7 == 3) ? 32'd0 : $urandom;
            if (i % 5 == 1) b = {{28{b[31]}}, b[3:0]};
            o = 1'($urandom_range(0, 1));
            model(o, a, b, ehi, elo, ez);
            load_y(a);
            issue(o, b);
            checks++;
            if (Zhigh !== phi || Zlow !== plo) begin
                errors++;
                $display("FAIL rnd_hold[%0d]: got %h_%h expected %h_%h", i, Zhigh, Zlow, phi, plo);
            end
            wait_done(lat, bad);
            checks += 5;
            if (lat != ((o && b == 32'd0) ? 1 : 33)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d op=%b b=%h", i, lat, o, b); end
            if (bad) begin errors++; $display("FAIL rnd_busy[%0d]: got bad busy/done overlap expected clean", i); end
            if (Zhigh !== ehi) begin errors++; $display("FAIL rnd_zhigh[%0d]: got %h expected %h (op=%b a=%h b=%h)", i, Zhigh, ehi, o, a, b); end
            if (Zlow !== elo) begin errors++; $display("FAIL rnd_zlow[%0d]: got %h expected %h (op=%b a=%h b=%h)", i, Zlow, elo, o, a, b); end
            if (dbz !== ez) begin errors++; $display("FAIL rnd_dbz[%0d]: got %b expected %b", i, dbz, ez); end
            phi = ehi;
            plo = elo;
        end
    endtask

    initial begin
        clear = 1'b0;
        BusMuxOut = '0;
        Yin = 1'b0;
        start = 1'b0;
        op = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_dbz;
        test_interference;
        test_clear_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
